watchdog_mc: RTL

WATCHDOG_MC -- requirements
Module: watchdog_mc

---
 rtl/watchdog_pkg.sv | 10 +
 rtl/watchdog_chan.sv | 50 +++++
 rtl/watchdog_mc.sv | 87 ++++++++
 3 files changed

// File: rtl/watchdog_pkg.sv
// watchdog_pkg: shared frame geometry helpers and channel state encoding
package watchdog_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BITE = 2'd2} chan_state_t;
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int frame_len(input int n, input int w);
    return ch_bits(n) + 2 + w;
  endfunction
endpackage

// File: rtl/watchdog_chan.sv
// watchdog_chan: one watchdog channel, timeout counter with optional early-kick window
module watchdog_chan
  import watchdog_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             i_commit,
  input  logic             i_en,
  input  logic             i_win,
  input  logic [WIDTH-1:0] i_top,
  input  logic             i_kick,
  output logic             o_woof
);
  chan_state_t      r_state;
  logic [WIDTH-1:0] r_top;
  logic [WIDTH-1:0] r_cnt;
  logic             r_win;
  logic             r_woof;
  // commit reloads the channel and overrides any kick in the same cycle
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_top   <= '0;
      r_cnt   <= '0;
      r_win   <= 1'b0;
      r_woof  <= 1'b0;
    end else if (i_commit) begin
      r_state <= (i_en && i_top != '0) ? RUN : IDLE;
      r_top   <= i_top;
      r_win   <= i_win;
      r_cnt   <= '0;
      r_woof  <= 1'b0;
    end else if (r_state == RUN) begin
      if (i_kick && r_win && r_cnt < (r_top >> 1)) begin
        r_state <= BITE;
        r_woof  <= 1'b1;
      end else if (i_kick) begin
        r_cnt <= '0;
      end else if (r_cnt == r_top) begin
        r_state <= BITE;
        r_woof  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
    end
  end
  assign o_woof = r_woof;
endmodule

// File: rtl/watchdog_mc.sv
// watchdog_mc: multi-channel watchdog configured through a synchronized serial frame port
module watchdog_mc
  import watchdog_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                sclk,
  input  logic                in,
  input  logic                sel,
  input  logic [CHANNELS-1:0] kick,
  output logic [CHANNELS-1:0] woof,
  output logic                woof_any,
  output logic                cfg_err
);
  localparam int CH_BITS = ch_bits(CHANNELS);
  localparam int FRAME   = frame_len(CHANNELS, WIDTH);
  localparam int CNT_W   = $clog2(FRAME + 2);
  logic [2:0]       r_sclk;
  logic [2:0]       r_sel;
  logic [1:0]       r_in;
  logic [1:0]       r_vld;
  logic             r_arm;
  logic             r_act;
  logic             r_err;
  logic [FRAME-1:0] r_shift;
  logic [CNT_W-1:0] r_bits;
  logic             w_sclk_rise;
  logic             w_sel_rise;
  logic             w_sel_fall;
  logic             w_ok;
  logic             w_commit;
  logic [CH_BITS-1:0] w_ch;
  assign w_sclk_rise = r_sclk[1] & ~r_sclk[2];
  assign w_sel_rise  = r_arm & r_sel[1] & ~r_sel[2];
  assign w_sel_fall  = r_act & ~r_sel[1] & r_sel[2];
  assign w_ch        = r_shift[FRAME-1 -: CH_BITS];
  assign w_ok        = (int'(r_bits) == FRAME) && (int'(w_ch) < CHANNELS);
  assign w_commit    = w_sel_fall & w_ok;
  // synchronize the serial port and assemble frames; a frame only starts on a sel rise seen after reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_sclk  <= '0;
      r_sel   <= '0;
      r_in    <= '0;
      r_vld   <= '0;
      r_arm   <= 1'b0;
      r_act   <= 1'b0;
      r_err   <= 1'b0;
      r_shift <= '0;
      r_bits  <= '0;
    end else begin
      r_sclk <= {r_sclk[1:0], sclk};
      r_sel  <= {r_sel[1:0], sel};
      r_in   <= {r_in[0], in};
      r_vld  <= {r_vld[0], 1'b1};
      r_arm  <= r_arm | (r_vld[1] & ~r_sel[1]);
      r_err  <= w_sel_fall & ~w_ok;
      if (w_sel_rise) begin
        r_act   <= 1'b1;
        r_shift <= '0;
        r_bits  <= '0;
      end else if (w_sel_fall) begin
        r_act <= 1'b0;
      end else if (r_act && w_sclk_rise) begin
        r_shift <= {r_shift[FRAME-2:0], r_in[1]};
        if (int'(r_bits) != FRAME + 1) r_bits <= r_bits + CNT_W'(1);
      end
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    watchdog_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .nRst     (nRst),
      .i_commit (w_commit && int'(w_ch) == i),
      .i_en     (r_shift[WIDTH+1]),
      .i_win    (r_shift[WIDTH]),
      .i_top    (r_shift[WIDTH-1:0]),
      .i_kick   (kick[i]),
      .o_woof   (woof[i])
    );
  end
  assign woof_any = |woof;
  assign cfg_err  = r_err;
endmodule
